// File: rtl/multimode_ring_counter.sv
// Multimode ring counter: one-hot ring or Johnson (twisted ring) sequencing in
// either direction, with synchronous load, illegal-state recovery to HOME and
// registered wrap/err pulses. A single register stage holds count/wrap/err.
module multimode_ring_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] HOME   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TOPBIT = HOME << (WIDTH-1);

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  function automatic logic ring_legal(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - HOME)) == '0);
  endfunction

  // At most one adjacent-bit transition. Bit i of t flags v[i] != v[i+1];
  // the top bit has no upper neighbour, so it is masked off.
  function automatic logic johnson_legal(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] t;
    t = (v ^ (v >> 1)) & ~TOPBIT;
    return (t & (t - HOME)) == '0;
  endfunction

  function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic m);
    return m ? johnson_legal(v) : ring_legal(v);
  endfunction

  // Rotate (ring) or twisted rotate (Johnson) by one position.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v,
                                                  input logic m, input logic d);
    logic [WIDTH-1:0] r;
    if (!d) r = {v[WIDTH-2:0], v[WIDTH-1] ^ m};
    else    r = {v[0] ^ m, v[WIDTH-1:1]};
    return r;
  endfunction

  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] shifted;
  logic             wrap_nxt;
  logic             err_nxt;

  // Next state: load has priority over advance; illegal states fall back to HOME.
  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    err_nxt   = 1'b0;
    shifted   = shift_once(count, mode, dir);
    if (load) begin
      if (is_legal(load_val, mode)) begin
        count_nxt = load_val;
      end else begin
        count_nxt = HOME;
        err_nxt   = 1'b1;
      end
    end else if (en) begin
      if (!is_legal(count, mode)) begin
        count_nxt = HOME;
        err_nxt   = 1'b1;
      end else begin
        count_nxt = shifted;
        wrap_nxt  = (shifted == HOME);
      end
    end
  end

  // State register; asynchronous active-low reset forces HOME immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= HOME;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_multimode_ring_counter.sv
// Testbench for multimode_ring_counter (WIDTH=4): directed vectors with literal
// expectations, plus an arithmetic reference model compared on every negedge.
module tb_multimode_ring_counter;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         dir;
  logic         mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         wrap;
  logic         err;

  int checks;
  int errors;

  multimode_ring_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .wrap     (wrap),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (arithmetic, not bit-slicing) ----------
  function automatic int ones(input logic [W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < W; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic bit model_legal(input logic [W-1:0] v, input logic m);
    int tr;
    if (!m) return ones(v) == 1;
    tr = 0;
    for (int i = 0; i < W - 1; i++) if (v[i] != v[i+1]) tr++;
    return tr <= 1;
  endfunction

  function automatic logic [W-1:0] model_shift(input logic [W-1:0] v, input logic m,
                                              input logic d);
    longint full;
    longint x;
    longint t;
    full = longint'(1) << W;
    x    = longint'(v);
    if (!d) begin
      t = x * 2;
      if (!m) begin
        if (t >= full) t = t - full + 1;
      end else begin
        if (t >= full) t = t - full;
        else           t = t + 1;
      end
    end else begin
      t = x / 2;
      if (!m) begin
        if (x % 2 == 1) t = t + full / 2;
      end else begin
        if (x % 2 == 0) t = t + full / 2;
      end
    end
    return t[W-1:0];
  endfunction

  logic [W-1:0] m_count;
  logic         m_wrap;
  logic         m_err;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_count = 1;
      m_wrap  = 1'b0;
      m_err   = 1'b0;
    end else if (load) begin
      m_wrap = 1'b0;
      if (model_legal(load_val, mode)) begin
        m_count = load_val;
        m_err   = 1'b0;
      end else begin
        m_count = 1;
        m_err   = 1'b1;
      end
    end else if (en) begin
      if (!model_legal(m_count, mode)) begin
        m_count = 1;
        m_err   = 1'b1;
        m_wrap  = 1'b0;
      end else begin
        m_count = model_shift(m_count, mode, dir);
        m_err   = 1'b0;
        m_wrap  = (m_count == 1);
      end
    end else begin
      m_wrap = 1'b0;
      m_err  = 1'b0;
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_count", 32'(count), 32'(m_count));
    chk("model_wrap", 32'(wrap), 32'(m_wrap));
    chk("model_err", 32'(err), 32'(m_err));
    chk("wrap_and_err_exclusive", 32'(wrap & err), 32'(1'b0));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lit(input string name, input logic [W-1:0] c, input logic w,
                            input logic e);
    chk({name, "_count"}, 32'(count), 32'(c));
    chk({name, "_wrap"}, 32'(wrap), 32'(w));
    chk({name, "_err"}, 32'(err), 32'(e));
  endtask

  logic [W-1:0] jseq [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    en       = 1'b0;
    dir      = 1'b0;
    mode     = 1'b0;
    load     = 1'b0;
    load_val = '0;
    jseq = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};

    #12;
    expect_lit("reset", 4'b0001, 1'b0, 1'b0);
    tick();
    rst = 1'b1;

    // Ring, left
    en = 1'b1;
    tick(); expect_lit("ring_l1", 4'b0010, 1'b0, 1'b0);
    tick(); expect_lit("ring_l2", 4'b0100, 1'b0, 1'b0);
    tick(); expect_lit("ring_l3", 4'b1000, 1'b0, 1'b0);
    tick(); expect_lit("ring_l4", 4'b0001, 1'b1, 1'b0);
    en = 1'b0;
    tick(); expect_lit("hold", 4'b0001, 1'b0, 1'b0);

    // Johnson, left
    mode = 1'b1;
    en   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_lit("john_l", jseq[i], (i == 7) ? 1'b1 : 1'b0, 1'b0);
    end

    // Johnson, right: full 2*W period back to HOME
    dir = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("john_r_before_wrap", 32'(wrap), 32'(1'b0));
    tick(); expect_lit("john_r8", 4'b0001, 1'b1, 1'b0);

    // Ring, right
    mode = 1'b0;
    tick(); expect_lit("ring_r1", 4'b1000, 1'b0, 1'b0);
    tick(); expect_lit("ring_r2", 4'b0100, 1'b0, 1'b0);
    tick(); expect_lit("ring_r3", 4'b0010, 1'b0, 1'b0);
    tick(); expect_lit("ring_r4", 4'b0001, 1'b1, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_lit("en_low_hold", 4'b0001, 1'b0, 1'b0);
    end

    // Loads in ring mode
    dir = 1'b0;
    load = 1'b1; load_val = 4'b0110;
    tick(); expect_lit("load_bad", 4'b0001, 1'b0, 1'b1);
    load_val = 4'b0100;
    tick(); expect_lit("load_good", 4'b0100, 1'b0, 1'b0);
    load_val = 4'b0000;
    tick(); expect_lit("load_zero_ring", 4'b0001, 1'b0, 1'b1);
    en = 1'b1; load_val = 4'b1000;
    tick(); expect_lit("load_over_en", 4'b1000, 1'b0, 1'b0);
    load = 1'b0; en = 1'b0;
    tick(); expect_lit("after_load_hold", 4'b1000, 1'b0, 1'b0);

    // Mode switch legality
    mode = 1'b1; load = 1'b1; load_val = 4'b0011;
    tick(); expect_lit("load_john", 4'b0011, 1'b0, 1'b0);
    load = 1'b0; mode = 1'b0; en = 1'b1;
    tick(); expect_lit("mode_switch_illegal", 4'b0001, 1'b0, 1'b1);
    tick(); expect_lit("recover_shift", 4'b0010, 1'b0, 1'b0);
    mode = 1'b1; load = 1'b1; load_val = 4'b1001;
    tick(); expect_lit("load_john_bad", 4'b0001, 1'b0, 1'b1);
    load_val = 4'b1111;
    tick(); expect_lit("load_john_ones", 4'b1111, 1'b0, 1'b0);
    load_val = 4'b0001;
    tick();
    load = 1'b0;

    // Asynchronous reset mid-cycle
    mode = 1'b0; dir = 1'b0; en = 1'b1;
    tick(); expect_lit("pre_rst1", 4'b0010, 1'b0, 1'b0);
    tick(); expect_lit("pre_rst2", 4'b0100, 1'b0, 1'b0);
    en = 1'b0;
    #2 rst = 1'b0;
    #1 expect_lit("async_rst", 4'b0001, 1'b0, 1'b0);
    tick();
    rst = 1'b1; en = 1'b1;
    tick(); expect_lit("post_rst", 4'b0010, 1'b0, 1'b0);
    en = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
